// File: rtl/uart_tx_sched_if.sv
// Requester-side valid/ready/data and uart_tx-side load/data/busy/tick bundle
// shared between the scheduler (master) and its environment (slave).
interface uart_tx_sched_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_load;
   logic [7:0]           tx_data;
   logic                 tx_busy;
   logic                 baud_tick;

   modport master (
      input  req_valid, req_data, tx_busy,
      output req_ready, tx_load, tx_data, baud_tick
   );

   modport slave (
      output req_valid, req_data, tx_busy,
      input  req_ready, tx_load, tx_data, baud_tick
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte requesters;
// also generates the transmitter's baud tick. All outputs are registered.
module uart_tx_sched #(
   parameter int NUM_REQ       = 4,
   parameter int BAUD_DIV      = 868,
   parameter int GAP_TICKS     = 0,
   parameter int START_TIMEOUT = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   uart_tx_sched_if.master            bus,
   input  logic                       en,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       active,
   output logic                       err_timeout
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int BCW = $clog2(BAUD_DIV);
   localparam int TOW = $clog2(START_TIMEOUT + 1);
   localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
   localparam logic [BCW-1:0] BAUD_PRE  = BCW'(BAUD_DIV - 2);
   localparam logic [TOW-1:0] TMO_LAST  = TOW'(START_TIMEOUT - 1);
   localparam logic [3:0]     GAP_LAST  = 4'(GAP_TICKS - 1);
   localparam logic [IDW:0]   NUM_W     = (IDW+1)'(NUM_REQ);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_DONE  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   state_t             state_r, state_s;
   logic [BCW-1:0]     baud_cnt_r;
   logic               baud_tick_r;
   logic [IDW-1:0]     last_r, last_s, grant_r, grant_s, win_s;
   logic [IDW:0]       idx_s;
   logic               found_s;
   logic [NUM_REQ-1:0] ready_r, ready_s;
   logic [7:0]         data_r, data_s;
   logic               load_r, load_s;
   logic               active_r, active_s;
   logic               err_r, err_s;
   logic [TOW-1:0]     tmo_r, tmo_s;
   logic [3:0]         gap_r, gap_s;

   // Free-running baud divider; tick is registered so it lines up with count BAUD_DIV-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt_r  <= {BCW{1'b0}};
         baud_tick_r <= 1'b0;
      end else begin
         if (baud_cnt_r == BAUD_LAST) begin
            baud_cnt_r <= {BCW{1'b0}};
         end else begin
            baud_cnt_r <= baud_cnt_r + BCW'(1);
         end
         baud_tick_r <= (baud_cnt_r == BAUD_PRE);
      end
   end

   // Round-robin search starting one past the last accepted requester.
   always_comb begin
      found_s = 1'b0;
      win_s   = {IDW{1'b0}};
      idx_s   = {(IDW+1){1'b0}};
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_s = (IDW+1)'(int'(last_r) + k);
         if (idx_s >= NUM_W) begin
            idx_s = idx_s - NUM_W;
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && bus.req_valid[idx_s[IDW-1:0]]) begin
            found_s = 1'b1;
            win_s   = idx_s[IDW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state and next-output logic; every output is registered one cycle later.
   always_comb begin
      state_s  = state_r;
      ready_s  = {NUM_REQ{1'b0}};
      load_s   = 1'b0;
      data_s   = data_r;
      grant_s  = grant_r;
      last_s   = last_r;
      active_s = active_r;
      err_s    = 1'b0;
      tmo_s    = tmo_r;
      gap_s    = gap_r;
      case (state_r)
         ST_IDLE: begin
            if (en && found_s) begin
               state_s        = ST_LOAD;
               ready_s[win_s] = 1'b1;
               data_s         = bus.req_data[{win_s, 3'b000} +: 8];
               grant_s        = win_s;
               last_s         = win_s;
               active_s       = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            load_s  = 1'b1;
            tmo_s   = {TOW{1'b0}};
            state_s = ST_START;
         end
         ST_START: begin
            if (bus.tx_busy) begin
               state_s = ST_DONE;
            end else if (tmo_r == TMO_LAST) begin
               err_s    = 1'b1;
               active_s = 1'b0;
               state_s  = ST_IDLE;
            end else begin
               tmo_s = tmo_r + TOW'(1);
            end
         end
         ST_DONE: begin
            if (bus.tx_busy) begin
               state_s = ST_DONE;
            end else if (GAP_TICKS > 0) begin
               gap_s   = 4'd0;
               state_s = ST_GAP;
            end else begin
               active_s = 1'b0;
               state_s  = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (!baud_tick_r) begin
               state_s = ST_GAP;
            end else if (gap_r == GAP_LAST) begin
               active_s = 1'b0;
               state_s  = ST_IDLE;
            end else begin
               gap_s = gap_r + 4'd1;
            end
         end
         default: begin
            active_s = 1'b0;
            state_s  = ST_IDLE;
         end
      endcase
   end

   // State and output registers; last_r resets so requester 0 wins first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         ready_r  <= {NUM_REQ{1'b0}};
         load_r   <= 1'b0;
         data_r   <= 8'h00;
         grant_r  <= {IDW{1'b0}};
         last_r   <= IDW'(NUM_REQ - 1);
         active_r <= 1'b0;
         err_r    <= 1'b0;
         tmo_r    <= {TOW{1'b0}};
         gap_r    <= 4'd0;
      end else begin
         state_r  <= state_s;
         ready_r  <= ready_s;
         load_r   <= load_s;
         data_r   <= data_s;
         grant_r  <= grant_s;
         last_r   <= last_s;
         active_r <= active_s;
         err_r    <= err_s;
         tmo_r    <= tmo_s;
         gap_r    <= gap_s;
      end
   end

   assign bus.req_ready = ready_r;
   assign bus.tx_load   = load_r;
   assign bus.tx_data   = data_r;
   assign bus.baud_tick = baud_tick_r;
   assign grant_id      = grant_r;
   assign active        = active_r;
   assign err_timeout   = err_r;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: table-driven round-robin vectors plus directed
// sequences for enable, line bits, timeout, reset mid-frame and gap.
module tb_uart_tx_sched;
   localparam int NR = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       en0, en1;
   logic [1:0] gid0, gid1;
   logic       act0, act1, err0, err1;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   uart_tx_sched_if #(.NUM_REQ(NR)) bus0 ();
   uart_tx_sched_if #(.NUM_REQ(NR)) bus1 ();

   uart_tx_sched #(.NUM_REQ(NR), .BAUD_DIV(4), .GAP_TICKS(0), .START_TIMEOUT(8)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .en(en0),
      .grant_id(gid0), .active(act0), .err_timeout(err0)
   );

   uart_tx_sched #(.NUM_REQ(NR), .BAUD_DIV(4), .GAP_TICKS(2), .START_TIMEOUT(8)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .en(en1),
      .grant_id(gid1), .active(act1), .err_timeout(err1)
   );

   // uart_tx stand-ins: load seen while idle, busy two clks later, drop 1 clk after 10th tick.
   logic       pend0, pend1, stuck, line0;
   logic [3:0] bcnt0, bcnt1;
   logic [7:0] cap0, cap1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bus0.tx_busy <= 1'b0; pend0 <= 1'b0; bcnt0 <= 4'd0; cap0 <= 8'h00;
      end else if (pend0) begin
         pend0 <= 1'b0; cap0 <= bus0.tx_data; bus0.tx_busy <= !stuck; bcnt0 <= 4'd0;
      end else if (bus0.tx_busy) begin
         if (bcnt0 == 4'd10) bus0.tx_busy <= 1'b0;
         else if (bus0.baud_tick) bcnt0 <= bcnt0 + 4'd1;
      end else if (bus0.tx_load) begin
         pend0 <= 1'b1;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bus1.tx_busy <= 1'b0; pend1 <= 1'b0; bcnt1 <= 4'd0; cap1 <= 8'h00;
      end else if (pend1) begin
         pend1 <= 1'b0; cap1 <= bus1.tx_data; bus1.tx_busy <= 1'b1; bcnt1 <= 4'd0;
      end else if (bus1.tx_busy) begin
         if (bcnt1 == 4'd10) bus1.tx_busy <= 1'b0;
         else if (bus1.baud_tick) bcnt1 <= bcnt1 + 4'd1;
      end else if (bus1.tx_load) begin
         pend1 <= 1'b1;
      end
   end

   always_comb begin
      line0 = 1'b1;
      if (bus0.tx_busy) begin
         if (bcnt0 == 4'd0) line0 = 1'b0;
         else if (bcnt0 <= 4'd8) line0 = cap0[3'(bcnt0 - 4'd1)];
         else line0 = 1'b1;
      end
   end

   // Protocol watch on dut0: one-hot, non-consecutive ready; no grant or load while busy.
   logic [3:0] prev_ready0 = 4'b0000;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus0.req_ready != 4'b0000) begin
            checks++;
            if (!$onehot(bus0.req_ready) || prev_ready0 != 4'b0000 || bus0.tx_busy) begin
               errors++;
               $display("FAIL ready_pulse: ready=%b prev=%b busy=%b, want one-hot, isolated, busy=0",
                        bus0.req_ready, prev_ready0, bus0.tx_busy);
            end
         end
         if (bus0.tx_load) begin
            checks++;
            if (bus0.tx_busy) begin
               errors++;
               $display("FAIL load_while_busy: tx_load=1 with tx_busy=1");
            end
         end
      end
      prev_ready0 <= bus0.req_ready;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic expire(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic wait_ready0(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (bus0.req_ready != 4'b0000) begin ok = 1'b1; break; end
      end
      if (!ok) expire("wait_ready");
   endtask

   task automatic wait_idle0();
      bit ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!act0) begin ok = 1'b1; break; end
      end
      if (!ok) expire("wait_idle");
   endtask

   task automatic wait_busy0(input logic want);
      bit ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (bus0.tx_busy == want) begin ok = 1'b1; break; end
      end
      if (!ok) expire("wait_busy");
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [3:0] valid;
      logic [3:0] ready;
      logic [1:0] id;
   } vec_t;
   vec_t tbl[12];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit         ok;
      int         n;
      logic [9:0] bits;
      logic [3:0] v;

      tbl[0]  = '{4'b1111, 4'b0001, 2'd0};
      tbl[1]  = '{4'b1111, 4'b0010, 2'd1};
      tbl[2]  = '{4'b1111, 4'b0100, 2'd2};
      tbl[3]  = '{4'b1111, 4'b1000, 2'd3};
      tbl[4]  = '{4'b1111, 4'b0001, 2'd0};
      tbl[5]  = '{4'b0100, 4'b0100, 2'd2};
      tbl[6]  = '{4'b0101, 4'b0001, 2'd0};
      tbl[7]  = '{4'b1010, 4'b0010, 2'd1};
      tbl[8]  = '{4'b1001, 4'b1000, 2'd3};
      tbl[9]  = '{4'b0110, 4'b0010, 2'd1};
      tbl[10] = '{4'b1000, 4'b1000, 2'd3};
      tbl[11] = '{4'b0011, 4'b0001, 2'd0};

      rst = 1'b1; en0 = 1'b0; en1 = 1'b0; stuck = 1'b0;
      bus0.req_valid = 4'b0000; bus0.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      bus1.req_valid = 4'b0000; bus1.req_data = {8'h13, 8'h22, 8'h11, 8'h10};
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_req_ready", 32'(bus0.req_ready), 32'h0);
      check("rst_tx_load",   32'(bus0.tx_load),   32'h0);
      check("rst_tx_data",   32'(bus0.tx_data),   32'h0);
      check("rst_baud_tick", 32'(bus0.baud_tick), 32'h0);
      check("rst_grant_id",  32'(gid0),           32'h0);
      check("rst_active",    32'(act0),           32'h0);
      check("rst_err",       32'(err0),           32'h0);

      // Baud tick every 4 clks (count 3 reached after the 3rd edge); en=0 blocks grants
      bus0.req_valid = 4'b0011;
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check("baud_tick", 32'(bus0.baud_tick), (k % 4 == 3) ? 32'h1 : 32'h0);
         check("no_grant_en0", 32'(bus0.req_ready), 32'h0);
      end
      en0 = 1'b1;
      @(negedge clk);
      check("en_grant_ready", 32'(bus0.req_ready), 32'h1);
      check("en_grant_id",    32'(gid0),           32'h0);
      check("en_grant_data",  32'(bus0.tx_data),   32'h10);
      bus0.req_valid = 4'b0000;
      wait_idle0();

      // Round-robin vectors; served requester drops, others keep requesting
      reset_pulse();
      for (int i = 0; i < 12; i++) begin
         bus0.req_valid = tbl[i].valid;
         wait_ready0(ok);
         if (ok) begin
            check("rr_ready", 32'(bus0.req_ready), 32'(tbl[i].ready));
            check("rr_grant", 32'(gid0),           32'(tbl[i].id));
            check("rr_data",  32'(bus0.tx_data),   32'h10 + 32'(tbl[i].id));
            check("rr_active", 32'(act0),          32'h1);
            v = tbl[i].valid & ~tbl[i].ready;
            bus0.req_valid = v;
            @(negedge clk);
            check("rr_load", 32'(bus0.tx_load), 32'h1);
         end
         wait_idle0();
      end
      bus0.req_valid = 4'b0000;
      @(negedge clk);

      // Single byte A5: timing, line bits LSB first, active drop one clk after busy falls
      reset_pulse();
      bus0.req_data[7:0] = 8'hA5;
      bus0.req_valid = 4'b0001;
      wait_ready0(ok);
      check("b1_ready", 32'(bus0.req_ready), 32'h1);
      check("b1_data",  32'(bus0.tx_data),   32'hA5);
      bus0.req_valid = 4'b0000;
      @(negedge clk);
      check("b1_load_n1", 32'(bus0.tx_load), 32'h1);
      @(negedge clk);
      check("b1_load_n2", 32'(bus0.tx_load), 32'h0);
      bits = 10'h000;
      n = 0;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (bus0.tx_busy && bus0.baud_tick && n < 10) begin
            bits = {line0, bits[9:1]};
            n++;
         end
         if (n == 10 && !bus0.tx_busy) begin ok = 1'b1; break; end
      end
      if (!ok) expire("b1_frame");
      check("b1_line_bits", 32'(bits), 32'({1'b1, 8'hA5, 1'b0}));
      check("b1_active_at_fall", 32'(act0), 32'h1);
      @(negedge clk);
      check("b1_active_after", 32'(act0), 32'h0);
      bus0.req_data[7:0] = 8'h10;

      // Timeout: busy never rises; err 8 clks after START entry, then RR resumes after 1
      reset_pulse();
      stuck = 1'b1;
      bus0.req_valid = 4'b0010;
      wait_ready0(ok);
      check("to_grant", 32'(gid0), 32'h1);
      bus0.req_valid = 4'b0000;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         check("to_err_early", 32'(err0), 32'h0);
      end
      @(negedge clk);
      check("to_err_pulse", 32'(err0), 32'h1);
      check("to_active",    32'(act0), 32'h0);
      stuck = 1'b0;
      bus0.req_valid = 4'b1011;
      wait_ready0(ok);
      check("to_err_clear",  32'(err0),           32'h0);
      check("to_next_ready", 32'(bus0.req_ready), 32'h8);
      check("to_next_grant", 32'(gid0),           32'h3);
      bus0.req_valid = 4'b0000;
      wait_idle0();

      // Reset 3 baud ticks into a frame
      reset_pulse();
      bus0.req_valid = 4'b0100;
      wait_ready0(ok);
      check("mr_grant", 32'(gid0), 32'h2);
      bus0.req_valid = 4'b0000;
      wait_busy0(1'b1);
      n = 0;
      for (int c = 0; c < 100; c++) begin
         if (n == 3) break;
         @(negedge clk);
         if (bus0.baud_tick) n++;
      end
      if (n != 3) expire("mr_ticks");
      rst = 1'b1;
      #1;
      check("mr_ready",  32'(bus0.req_ready), 32'h0);
      check("mr_load",   32'(bus0.tx_load),   32'h0);
      check("mr_data",   32'(bus0.tx_data),   32'h0);
      check("mr_tick",   32'(bus0.baud_tick), 32'h0);
      check("mr_grant0", 32'(gid0),           32'h0);
      check("mr_active", 32'(act0),           32'h0);
      check("mr_err",    32'(err0),           32'h0);
      check("mr_line",   32'(line0),          32'h1);
      @(negedge clk);
      rst = 1'b0;
      bus0.req_valid = 4'b1111;
      wait_ready0(ok);
      check("mr_first_ready", 32'(bus0.req_ready), 32'h1);
      check("mr_first_grant", 32'(gid0),           32'h0);
      bus0.req_valid = 4'b0000;
      wait_idle0();

      // Gap of 2 baud ticks between frames of a streaming requester (dut1)
      en1 = 1'b1;
      bus1.req_valid = 4'b0100;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (bus1.req_ready != 4'b0000) begin ok = 1'b1; break; end
      end
      if (!ok) expire("gap_first_ready");
      check("gap_first_ready", 32'(bus1.req_ready), 32'h4);
      bus1.req_data[23:16] = 8'h33;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (bus1.tx_busy) begin ok = 1'b1; break; end
      end
      if (!ok) expire("gap_busy_rise");
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!bus1.tx_busy) begin ok = 1'b1; break; end
      end
      if (!ok) expire("gap_busy_fall");
      n = 0;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (bus1.tx_load) begin ok = 1'b1; break; end
         if (bus1.baud_tick) n++;
         @(negedge clk);
      end
      if (!ok) expire("gap_second_load");
      check("gap_ticks",       32'(n),            32'd2);
      check("gap_second_data", 32'(bus1.tx_data), 32'h33);
      check("gap_second_grant", 32'(gid1),        32'h2);
      bus1.req_valid = 4'b0000;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
